fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
- Upstream stage of fft_control; fills the four radix-4 data banks with one frame of N complex samples in digit-reversed, conflict-free order.
- Fires a one-cycle start to fft_control, then blocks further input until the transform completes.
- Streaming valid/ready input on one side; four-bank RAM write port and the control handshake on the other.

Parameters:
- N_POINTS, 256, FFT length; must be a power of 4 (at least 16).
- DATA_W, 16, width of each real/imag sample.
- ADDR_W, $clog2(N_POINTS/4), per-bank address width (bank depth N/4).

Ports:
- iCLK in 1: system clock.
- iRESET in 1: asynchronous active-high reset.
- iDATA_RE in DATA_W: input sample, real part.
- iDATA_IM in DATA_W: input sample, imaginary part.
- iVALID in 1: input sample valid.
- oREADY out 1: loader accepts a sample this cycle.
- iFFT_RDY in 1: oRDY of fft_control; rising edge = transform done.
- oWR_EN out 4: one-hot bank write strobe.
- oWR_ADDR out ADDR_W: bank write address.
- oWR_RE out DATA_W: write data, real part.
- oWR_IM out DATA_W: write data, imaginary part.
- oSTART out 1: one-cycle start pulse to fft_control iSTART.
- oBUSY out 1: high from oSTART until the FFT-done edge.

Behaviour:
- Reset (asynchronous, active-high): state=LOAD, sample counter n=0, oREADY=1, oWR_EN=0, oWR_ADDR=0, oWR_RE=0, oWR_IM=0, oSTART=0, oBUSY=0, iFFT_RDY edge register=0.
- Accept rule: a sample is accepted on a cycle where iVALID && oREADY; n increments on each accept.
- iVALID low stalls the frame; no counting, no writes. Gaps of any length are legal.
- Address mapping, D = log4(N_POINTS) digits, n = d[D-1]..d[0] in base 4:
  - r = base-4 digit reversal of n;
  - bank = (sum of all d[i]) mod 4;
  - addr = r >> 2.
  - This mapping is bijective over the N/4 x 4 locations.
- Write latency: 1 cycle, registered.
  - Accept in cycle t gives oWR_EN[bank]=1 with oWR_ADDR/oWR_RE/oWR_IM valid in cycle t+1.
  - oWR_EN is all-zero otherwise.
- States:
  - LOAD: oREADY=1.
    - Accept with n=N-1 -> START_P; oREADY drops the following cycle; n wraps to 0.
  - START_P: oREADY=0. Lasts one cycle; this cycle carries the final write strobe.
    - Next cycle oSTART=1 for exactly one cycle and oBUSY=1 -> WAIT_FFT.
    - oSTART therefore occurs at t_last+2.
  - WAIT_FFT: oREADY=0, oBUSY=1, no writes.
    - A rising edge of iFFT_RDY (registered compare, iFFT_RDY && !prev) -> LOAD.
    - oBUSY=0 and oREADY=1 on the cycle after the edge is seen.
    - Both pulse-style and level-style iFFT_RDY are handled by the edge detector.
    - An edge occurring on the oSTART cycle itself is ignored; the edge register is reloaded at oSTART.
- iFFT_RDY edges in LOAD/START_P are ignored.
- Reset mid-frame: partial frame discarded, n=0, no oSTART issued, return to LOAD.
- Reset in WAIT_FFT: return to LOAD; fft_control is reset by the same line.
- The loader never writes while oBUSY=1; banks are owned by the FFT datapath then.

Decomposition:
- Shared package fft_pkg holds:
  - LOG4N / ADDR_W derivation function;
  - typedef cplx_t {re, im};
  - bank-index typedef (2 bits);
  - loader state enum {LOAD, START_P, WAIT_FFT}.
- One sub-module, fft_digit_rev_map: combinational, n -> {bank, addr}, parameterised by N_POINTS.
  - Reusable by the output unloader and by the bench scoreboard.

Test Plan (N_POINTS=16, DATA_W=16 unless noted):
- Mapping: stream n=0..15 with iVALID held high -> writes seen for:
  - n=0 at bank0/addr0;
  - n=1 at oWR_EN=4'b0010, addr1;
  - n=4 at bank1/addr0;
  - n=5 at bank2/addr1;
  - n=15 at bank2/addr3.
  - All 16 {bank,addr} pairs are unique.
- Timing: last accept at cycle T -> final oWR_EN at T+1, oSTART=1 only at T+2, oREADY=0 from T+1, oBUSY=1 from T+2.
- Stall: iVALID toggled 1/0 randomly across the frame -> identical bank contents to the back-to-back run; exactly 16 write strobes; one oSTART.
- Handshake: hold iFFT_RDY=1 through START_P, drop to 0 for 50 cycles, then raise -> oREADY returns to 1 exactly one cycle after the rise.
  - A second frame of 16 samples produces a second oSTART.
- Reset mid-frame: async iRESET after 7 accepts -> all outputs at reset values immediately.
  - After release, a full 16-sample frame is needed before oSTART; no strobe is carried over.
- Scale: N_POINTS=256 with the fft_control model attached -> 256 writes, one start, RDY edge releases the loader.
  - Two consecutive frames are loaded correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and size helpers for the radix-4 FFT front end.
//   log4()   : number of base-4 digits in an FFT length
//   addr_w() : per-bank address width (bank depth N/4)
//   cplx_t   : complex sample container {re, im}
//   bank_t   : radix-4 bank index
//   loader_state_e : input loader FSM states
package fft_pkg;

  localparam int SAMPLE_W = 16;

  function automatic int log4(input int n);
    int d;
    d = 0;
    for (int v = n; v > 1; v = v / 4) d++;
    return d;
  endfunction

  function automatic int addr_w(input int n);
    return $clog2(n / 4);
  endfunction

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {LOAD, START_P, WAIT_FFT} loader_state_e;

endpackage

// File: rtl/fft_digit_rev_map.sv
// Combinational sample-index -> {bank, addr} map for the four radix-4 banks.
//   n    : natural-order sample index (log2(N_POINTS) bits)
//   bank : sum of the base-4 digits of n, mod 4
//   addr : base-4 digit reversal of n, dropping the lowest reversed digit
// Each radix-4 butterfly group lands in four different banks, so the
// transform can read all four operands in one cycle.
module fft_digit_rev_map
  import fft_pkg::*;
#(
  parameter int N_POINTS = 256
) (
  input  logic [2*log4(N_POINTS)-1:0] n,
  output bank_t                        bank,
  output logic [2*log4(N_POINTS)-3:0]  addr
);

  localparam int D = log4(N_POINTS);

  logic [2*D-1:0] rev;
  bank_t          dsum;

  always_comb begin
    rev  = '0;
    dsum = '0;
    for (int i = 0; i < D; i++) begin
      rev[2*(D-1-i) +: 2] = n[2*i +: 2];
      dsum                = dsum + n[2*i +: 2];  // 2-bit wrap gives mod 4
    end
  end

  assign bank = dsum;
  assign addr = rev[2*D-1:2];

endmodule

// File: rtl/fft_input_loader.sv
// Loads one frame of N complex samples into the four radix-4 banks in
// digit-reversed order, then starts fft_control and holds off input until
// the transform reports done.
//   iCLK, iRESET          : clock, async active-high reset
//   iDATA_RE/IM, iVALID   : streaming sample input
//   oREADY                : sample accepted when iVALID && oREADY
//   iFFT_RDY              : fft_control ready; its rising edge = done
//   oWR_EN/ADDR/RE/IM     : registered bank write port (one-hot bank strobe)
//   oSTART                : one-cycle start pulse to fft_control
//   oBUSY                 : high from oSTART until the done edge
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N_POINTS = 256,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = addr_w(N_POINTS)
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iDATA_RE,
  input  logic [DATA_W-1:0] iDATA_IM,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic              iFFT_RDY,
  output logic [3:0]        oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [DATA_W-1:0] oWR_RE,
  output logic [DATA_W-1:0] oWR_IM,
  output logic              oSTART,
  output logic              oBUSY
);

  localparam int NW = 2 * log4(N_POINTS);

  loader_state_e     state_q, state_d;
  logic [NW-1:0]     n_q;
  logic              start_q;
  logic              fft_rdy_q;
  logic              accept;
  logic              last;
  logic              rdy_edge;
  bank_t             map_bank;
  logic [ADDR_W-1:0] map_addr;

  fft_digit_rev_map #(.N_POINTS(N_POINTS)) u_map (
    .n    (n_q),
    .bank (map_bank),
    .addr (map_addr)
  );

  // Accept decoded from the state register, not from oREADY, so the
  // next-state logic has no path back through its own output.
  assign accept = iVALID && (state_q == LOAD);
  assign last   = (n_q == NW'(N_POINTS - 1));
  // The edge register is reloaded on the oSTART cycle; a rise seen there
  // belongs to the previous transform and is dropped.
  assign rdy_edge = iFFT_RDY && !fft_rdy_q && !start_q;
  assign oSTART   = start_q;

  always_comb begin
    state_d = state_q;
    oREADY  = 1'b0;
    oBUSY   = 1'b0;
    case (state_q)
      LOAD: begin
        oREADY = 1'b1;
        if (accept && last) state_d = START_P;
      end
      START_P: state_d = WAIT_FFT;
      WAIT_FFT: begin
        oBUSY = 1'b1;
        if (rdy_edge) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= LOAD;
      n_q       <= '0;
      start_q   <= 1'b0;
      fft_rdy_q <= 1'b0;
      oWR_EN    <= '0;
      oWR_ADDR  <= '0;
      oWR_RE    <= '0;
      oWR_IM    <= '0;
    end else begin
      state_q   <= state_d;
      fft_rdy_q <= iFFT_RDY;
      start_q   <= (state_q == START_P);
      oWR_EN    <= '0;
      if (accept) begin
        n_q      <= n_q + NW'(1);  // wraps to 0 after the last sample
        oWR_EN   <= 4'b0001 << map_bank;
        oWR_ADDR <= map_addr;
        oWR_RE   <= iDATA_RE;
        oWR_IM   <= iDATA_IM;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

  localparam int N1  = 16;
  localparam int N2  = 256;
  localparam int DW  = 16;
  localparam int AW1 = 2;
  localparam int AW2 = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]  re1 = '0, im1 = '0, re2 = '0, im2 = '0;
  logic           vld1 = 1'b0, vld2 = 1'b0, frdy1 = 1'b1, frdy2 = 1'b1;
  logic           rdy1, start1, busy1, rdy2, start2, busy2;
  logic [3:0]     en1, en2;
  logic [AW1-1:0] addr1;
  logic [AW2-1:0] addr2;
  logic [DW-1:0]  wre1, wim1, wre2, wim2;

  fft_input_loader #(.N_POINTS(N1), .DATA_W(DW), .ADDR_W(AW1)) dut1 (
    .iCLK(clk), .iRESET(rst), .iDATA_RE(re1), .iDATA_IM(im1), .iVALID(vld1),
    .oREADY(rdy1), .iFFT_RDY(frdy1), .oWR_EN(en1), .oWR_ADDR(addr1),
    .oWR_RE(wre1), .oWR_IM(wim1), .oSTART(start1), .oBUSY(busy1));

  fft_input_loader #(.N_POINTS(N2), .DATA_W(DW), .ADDR_W(AW2)) dut2 (
    .iCLK(clk), .iRESET(rst), .iDATA_RE(re2), .iDATA_IM(im2), .iVALID(vld2),
    .oREADY(rdy2), .iFFT_RDY(frdy2), .oWR_EN(en2), .oWR_ADDR(addr2),
    .oWR_RE(wre2), .oWR_IM(wim2), .oSTART(start2), .oBUSY(busy2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference map from plain base-4 arithmetic.
  function automatic int ref_bank(input int n, input int npts);
    int s, v;
    s = 0; v = n;
    for (int k = 1; k < npts; k *= 4) begin s += v % 4; v /= 4; end
    return s % 4;
  endfunction

  function automatic int ref_addr(input int n, input int npts);
    int r, v;
    r = 0; v = n;
    for (int k = 1; k < npts; k *= 4) begin r = r * 4 + v % 4; v /= 4; end
    return r / 4;
  endfunction

  function automatic logic [DW-1:0] s_re(input int base, input int i);
    return DW'(base + 3 * i);
  endfunction

  function automatic logic [DW-1:0] s_im(input int base, input int i);
    return DW'(base * 7 + 40000 - i);
  endfunction

  function automatic int bank_of(input logic [3:0] e);
    case (e)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Timeline model of the N=16 loader: frame ends at the N-th accept (t_last);
  // input closed from t_last+1, start at t_last+2, busy from t_last+2 until the
  // cycle after the first iFFT_RDY rise seen at t_last+3 or later.
  int          cyc = 0, t_last = -10, acc_cnt = 0;
  bit          waiting = 1'b0, m_prev = 1'b0, rel;
  logic [3:0]     x_en = '0;
  logic [AW1-1:0] x_addr = '0;
  logic [DW-1:0]  x_re = '0, x_im = '0;
  bit          x_ready = 1'b1, x_start = 1'b0, x_busy = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      waiting = 1'b0; acc_cnt = 0; m_prev = 1'b0;
      x_en = '0; x_addr = '0; x_re = '0; x_im = '0;
      x_ready = 1'b1; x_start = 1'b0; x_busy = 1'b0;
    end else begin
      rel    = waiting && (cyc >= t_last + 3) && frdy1 && !m_prev;
      m_prev = frdy1;
      x_en   = '0;
      if (vld1 && x_ready) begin
        x_en   = 4'(1 << ref_bank(acc_cnt, N1));
        x_addr = AW1'(ref_addr(acc_cnt, N1));
        x_re   = re1;
        x_im   = im1;
        acc_cnt++;
        if (acc_cnt == N1) begin acc_cnt = 0; waiting = 1'b1; t_last = cyc; end
      end
      if (rel) waiting = 1'b0;
      cyc++;
      x_ready = !waiting;
      x_start = waiting && (cyc == t_last + 2);
      x_busy  = waiting && (cyc >= t_last + 2);
    end
  end

  // Per-cycle compare for DUT1, plus write/start logging for both DUTs.
  int             w_cnt1 = 0, st_cnt1 = 0, st_cyc1 = 0, w_cnt2 = 0, st_cnt2 = 0;
  logic [3:0]     log_en1 [32];
  logic [AW1-1:0] log_addr1 [32];
  logic [2*DW-1:0] mem1 [N1];
  logic [2*DW-1:0] mem2 [N2];
  int             seen1 [N1];
  int             seen2 [N2];

  initial forever begin
    int b;
    @(negedge clk);
    chk("ready1", 32'(rdy1), 32'(x_ready));
    chk("start1", 32'(start1), 32'(x_start));
    chk("busy1", 32'(busy1), 32'(x_busy));
    chk("wr_en1", 32'(en1), 32'(x_en));
    if (x_en != 0) begin
      chk("wr_addr1", 32'(addr1), 32'(x_addr));
      chk("wr_re1", 32'(wre1), 32'(x_re));
      chk("wr_im1", 32'(wim1), 32'(x_im));
    end
    if (en1 != 0) begin
      if (w_cnt1 < 32) begin log_en1[w_cnt1] = en1; log_addr1[w_cnt1] = addr1; end
      w_cnt1++;
      b = bank_of(en1);
      if (b >= 0) begin
        mem1[b*(N1/4) + int'(addr1)] = {wre1, wim1};
        seen1[b*(N1/4) + int'(addr1)]++;
      end
    end
    if (start1) begin st_cnt1++; st_cyc1 = cyc; end
    if (en2 != 0) begin
      w_cnt2++;
      b = bank_of(en2);
      if (b >= 0) begin
        mem2[b*(N2/4) + int'(addr2)] = {wre2, wim2};
        seen2[b*(N2/4) + int'(addr2)]++;
      end
    end
    if (start2) st_cnt2++;
  end

  task automatic clear1();
    w_cnt1 = 0; st_cnt1 = 0;
    for (int i = 0; i < N1; i++) begin seen1[i] = 0; mem1[i] = '0; end
  endtask

  task automatic clear2();
    w_cnt2 = 0; st_cnt2 = 0;
    for (int i = 0; i < N2; i++) begin seen2[i] = 0; mem2[i] = '0; end
  endtask

  // Drive samples first..last-1; t_acc gets the cycle of the frame's final accept.
  task automatic frame1(input int base, input bit stall, input int first, input int last,
                        output int t_acc);
    int i, guard;
    i = first; guard = 0; t_acc = -1;
    while (i < last) begin
      @(posedge clk); #1;
      vld1 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      re1  = s_re(base, i);
      im1  = s_im(base, i);
      if (vld1 && x_ready) begin
        if (i == N1 - 1) t_acc = cyc;
        i++;
      end
      if (++guard > 400) begin tmo("frame1"); break; end
    end
    @(posedge clk); #1;
    vld1 = 1'b0;
  endtask

  task automatic frame2(input int base);
    int i;
    bit gap;
    i = 0; gap = 1'b0;
    while (i < N2) begin
      @(posedge clk); #1;
      if ((i % 37 == 5) && !gap) begin vld2 = 1'b0; gap = 1'b1; end
      else begin vld2 = 1'b1; re2 = s_re(base, i); im2 = s_im(base, i); i++; gap = 1'b0; end
    end
    @(posedge clk); #1;
    vld2 = 1'b0;
  endtask

  task automatic wait_start1(input int want);
    int k;
    k = 0;
    while (st_cnt1 < want && k < 30) begin @(posedge clk); k++; end
    if (st_cnt1 < want) tmo("start1_wait");
    else chk("start1_count", 32'(st_cnt1), 32'(want));
  endtask

  task automatic wait_start2();
    int k;
    k = 0;
    while (st_cnt2 < 1 && k < 30) begin @(posedge clk); k++; end
    if (st_cnt2 < 1) tmo("start2_wait");
  endtask

  task automatic check_mem1(input int base, input string tag);
    for (int i = 0; i < N1; i++) begin
      int loc;
      loc = ref_bank(i, N1) * (N1/4) + ref_addr(i, N1);
      chk({tag, "_seen"}, 32'(seen1[loc]), 32'd1);
      chk({tag, "_data"}, mem1[loc], {s_re(base, i), s_im(base, i)});
    end
  endtask

  task automatic check_mem2(input int base, input string tag);
    for (int i = 0; i < N2; i++) begin
      int loc;
      loc = ref_bank(i, N2) * (N2/4) + ref_addr(i, N2);
      chk({tag, "_seen"}, 32'(seen2[loc]), 32'd1);
      chk({tag, "_data"}, mem2[loc], {s_re(base, i), s_im(base, i)});
    end
  endtask

  // fft_control stand-in for DUT2: ready drops after start, rises when done.
  task automatic run_fft2(input string tag);
    wait_start2();
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy2), 32'd1);
    chk({tag, "_ready_low"}, 32'(rdy2), 32'd0);
    @(posedge clk); #1 frdy2 = 1'b0;
    repeat (30) @(posedge clk);
    #1 frdy2 = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_rise_cyc"}, 32'(rdy2), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(rdy2), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    int ta, tdummy;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'd1);
    chk("rst_en", 32'(en1), 32'd0);
    chk("rst_addr", 32'(addr1), 32'd0);
    chk("rst_re", 32'(wre1), 32'd0);
    chk("rst_im", 32'(wim1), 32'd0);
    chk("rst_start", 32'(start1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ready2", 32'(rdy2), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Model pins against hand-derived map values.
    chk("ref_bank_n1", 32'(ref_bank(1, N1)), 32'd1);
    chk("ref_addr_n5", 32'(ref_addr(5, N1)), 32'd1);
    chk("ref_bank_n15", 32'(ref_bank(15, N1)), 32'd2);
    chk("ref_addr_n15", 32'(ref_addr(15, N1)), 32'd3);

    // Back-to-back frame with iFFT_RDY held high throughout.
    clear1();
    frame1(100, 1'b0, 0, N1, ta);
    wait_start1(1);
    chk("start_latency", 32'(st_cyc1 - ta), 32'd2);
    chk("writes_a", 32'(w_cnt1), 32'd16);
    chk("map_n0_en", 32'(log_en1[0]), 32'b0001);
    chk("map_n0_addr", 32'(log_addr1[0]), 32'd0);
    chk("map_n1_en", 32'(log_en1[1]), 32'b0010);
    chk("map_n1_addr", 32'(log_addr1[1]), 32'd1);
    chk("map_n4_en", 32'(log_en1[4]), 32'b0010);
    chk("map_n4_addr", 32'(log_addr1[4]), 32'd0);
    chk("map_n5_en", 32'(log_en1[5]), 32'b0100);
    chk("map_n5_addr", 32'(log_addr1[5]), 32'd1);
    chk("map_n15_en", 32'(log_en1[15]), 32'b0100);
    chk("map_n15_addr", 32'(log_addr1[15]), 32'd3);
    check_mem1(100, "mem_a");

    // Level-style done: drop for 50 cycles, then rise.
    repeat (2) @(posedge clk);
    #1 frdy1 = 1'b0;
    repeat (50) @(posedge clk);
    #1 frdy1 = 1'b1;
    @(negedge clk);
    chk("hs_ready_on_rise", 32'(rdy1), 32'd0);
    chk("hs_busy_on_rise", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("hs_ready_after", 32'(rdy1), 32'd1);
    chk("hs_busy_after", 32'(busy1), 32'd0);
    chk("hs_one_start", 32'(st_cnt1), 32'd1);

    // Stalled frame, same data: same bank image, one start; pulse-style done.
    clear1();
    frame1(100, 1'b1, 0, N1, ta);
    wait_start1(1);
    repeat (4) @(posedge clk);
    chk("stall_writes", 32'(w_cnt1), 32'd16);
    chk("stall_one_start", 32'(st_cnt1), 32'd1);
    check_mem1(100, "mem_stall");
    #1 frdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 frdy1 = 1'b1;
    @(negedge clk);
    chk("pulse_ready_on_rise", 32'(rdy1), 32'd0);
    @(posedge clk); #1 frdy1 = 1'b0;
    @(negedge clk);
    chk("pulse_ready_after", 32'(rdy1), 32'd1);

    // Reset after 7 accepts: outputs clear at once, frame restarts from 0.
    clear1();
    frame1(500, 1'b0, 0, 7, tdummy);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(en1), 32'd0);
    chk("mid_rst_ready", 32'(rdy1), 32'd1);
    chk("mid_rst_addr", 32'(addr1), 32'd0);
    chk("mid_rst_re", 32'(wre1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear1();
    frame1(700, 1'b0, 0, 9, tdummy);
    repeat (4) @(posedge clk);
    chk("post_rst_no_start", 32'(st_cnt1), 32'd0);
    frame1(700, 1'b0, 9, N1, ta);
    // Rise on the start cycle itself must be ignored.
    @(posedge clk); #1 frdy1 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("start_cycle_edge_ignored", 32'(busy1), 32'd1);
    chk("post_rst_writes", 32'(w_cnt1), 32'd16);
    chk("post_rst_one_start", 32'(st_cnt1), 32'd1);
    check_mem1(700, "mem_rst");
    @(posedge clk); #1 frdy1 = 1'b0;
    @(posedge clk); #1 frdy1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_release", 32'(rdy1), 32'd1);

    // N=256 loader, two consecutive frames.
    clear2();
    frame2(1234);
    run_fft2("big1");
    chk("big1_writes", 32'(w_cnt2), 32'd256);
    chk("big1_one_start", 32'(st_cnt2), 32'd1);
    check_mem2(1234, "big1_mem");
    clear2();
    frame2(9000);
    run_fft2("big2");
    chk("big2_writes", 32'(w_cnt2), 32'd256);
    chk("big2_one_start", 32'(st_cnt2), 32'd1);
    check_mem2(9000, "big2_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
